regfile_wr_arbiter: RTL and testbench
=====================================

// Module: regfile_wr_arbiter
// PURPOSE
//  - Owns the single write port (i_rd_wren/i_rd_addr/i_rd_data) of the 32x32 2R1W regfile.
//  - After reset it scrubs x1..x31 to zero, then shares the port round-robin among N_REQ
//    writeback requesters (ALU, load return, CSR, ...) over valid/ready handshakes.
//  - Sits between the writeback sources and the regfile; the regfile read side is untouched.
// PARAMETERS
//  - N_REQ     default 3     number of requesters, 2..8
//  - SCRUB_EN  default 1'b1  1: run INIT scrub after reset; 0: reset goes straight to ARB
// PORTS
//  - i_clk         in   1         clock, all state on rising edge
//  - i_rstn        in   1         asynchronous active-low reset
//  - i_scrub       in   1         request a re-scrub (level sampled in ARB)
//  - i_req_valid   in   N_REQ     per-requester write request
//  - i_req_addr    in   5*N_REQ   dest reg, requester k at [5k+4:5k]
//  - i_req_data    in   32*N_REQ  write data, requester k at [32k+31:32k]
//  - o_req_ready   out  N_REQ     one-hot grant; handshake = valid & ready
//  - o_rd_wren     out  1         to regfile write enable (registered)
//  - o_rd_addr     out  5         to regfile write address (registered)
//  - o_rd_data     out  32        to regfile write data (registered)
//  - o_grant_id    out  3         index of requester whose write is on o_rd_* (registered)
//  - o_init_done   out  1         1 in ARB, 0 in INIT (registered)
// BEHAVIOUR
//  - Reset (async): state=INIT (ARB if SCRUB_EN=0), scrub cnt=1, rr_ptr=0, o_rd_wren=0,
//    o_rd_addr=0, o_rd_data=0, o_grant_id=0, o_init_done=0 (1 if SCRUB_EN=0). Reset mid-scrub
//    restarts the scrub from x1.
//  - INIT: each cycle register o_rd_wren=1, o_rd_addr=cnt, o_rd_data=0, cnt++; o_req_ready=0.
//    After the cnt=31 cycle -> ARB, o_init_done=1 on the same edge. 31 write cycles total.
//  - ARB, i_scrub=1: o_req_ready=0 that cycle, next state INIT with cnt=1, o_init_done=0.
//  - ARB, i_scrub=0: o_req_ready combinational, one-hot at first k with i_req_valid[k]=1
//    searching rr_ptr, rr_ptr+1, ... mod N_REQ; all-zero if no valid.
//  - Handshake on k: next edge o_rd_wren=1, o_rd_addr/o_rd_data=req k fields, o_grant_id=k,
//    rr_ptr=(k+1) mod N_REQ. No handshake: o_rd_wren=0, addr/data/grant_id hold, rr_ptr holds.
//  - Latency: handshake at cycle t -> regfile write at edge ending cycle t+1; max throughput
//    1 write/cycle; every valid requester granted within N_REQ ARB cycles.
//  - Requesters hold valid/addr/data stable until handshake; ready may depend on valid.
//  - Same dest from two requesters: each write issued in grant order; last grant wins.
// CONFIGURATION
//  - RFARB_X0_DROP_EN defined: handshake with addr=0 completes (ready=1, rr_ptr advances)
//    but next-edge o_rd_wren=0; addr/data/grant_id hold.
//  - Not defined: addr=0 writes forwarded as normal (o_rd_wren=1, o_rd_addr=0); regfile
//    discards them.
// TESTING
//  - Reset release, SCRUB_EN=1 -> 31 cycles o_rd_wren=1, addr 1..31, data 0; then
//    o_init_done=1, o_rd_wren=0; any valid during INIT sees ready=0.
//  - N_REQ=3, all valid continuously (addr 5/6/7) -> grants 0,1,2,0,1,2; o_rd_wren=1 every cycle.
//  - Only req1 valid (addr 9, data 0xDEADBEEF) -> ready[1]=1; next cycle wren=1, addr=9,
//    data=0xDEADBEEF, grant_id=1.
//  - Req0 and req2 both addr 4, data 0x11/0x22, rr_ptr=0 -> writes 0x11 then 0x22, last=0x22.
//  - i_scrub=1 in ARB with req0 valid -> ready=0, 31-cycle scrub, then req0 granted.
//  - Req0 addr 0 -> with RFARB_X0_DROP_EN: ready=1, wren stays 0; without: wren=1, addr=0.
//  - i_rstn low at scrub cnt=17 -> outputs reset at once; after release scrub restarts at x1.

Source files
------------

// File: rtl/regfile_wr_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wr_arbiter
//
// Owns the single write port of the 32x32 2R1W integer regfile. After reset it
// scrubs x1..x31 to zero (INIT), then shares the port round-robin among N_REQ
// writeback requesters over valid/ready handshakes (ARB). A level on i_scrub
// seen in ARB re-runs the scrub.
//
// Ports
//   i_clk        clock, all state on rising edge
//   i_rstn       asynchronous active-low reset
//   i_scrub      request a re-scrub (sampled in ARB)
//   i_req_valid  per-requester write request
//   i_req_addr   dest reg, requester k at [5k+4:5k]
//   i_req_data   write data, requester k at [32k+31:32k]
//   o_req_ready  one-hot grant (combinational); handshake = valid & ready
//   o_rd_wren    regfile write enable (registered)
//   o_rd_addr    regfile write address (registered)
//   o_rd_data    regfile write data (registered)
//   o_grant_id   requester whose write is on o_rd_* (registered)
//   o_init_done  1 in ARB, 0 while scrubbing (registered)
//
// Build option
//   RFARB_X0_DROP_EN : when defined, a handshake targeting x0 completes
//                      normally but no write is issued to the regfile.
// -----------------------------------------------------------------------------
module regfile_wr_arbiter #(
    parameter int N_REQ    = 3,
    parameter bit SCRUB_EN = 1'b1
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_scrub,
    input  logic [N_REQ-1:0]      i_req_valid,
    input  logic [5*N_REQ-1:0]    i_req_addr,
    input  logic [32*N_REQ-1:0]   i_req_data,
    output logic [N_REQ-1:0]      o_req_ready,
    output logic                  o_rd_wren,
    output logic [4:0]            o_rd_addr,
    output logic [31:0]           o_rd_data,
    output logic [2:0]            o_grant_id,
    output logic                  o_init_done
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_ARB  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [2:0]  rr_ptr_q, rr_ptr_d;
    logic        wren_q, wren_d;
    logic [4:0]  addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [2:0]  gid_q, gid_d;
    logic        init_done_q, init_done_d;

    logic        gnt_found;
    logic [2:0]  gnt_idx;
    logic        gnt_ok;
    logic [4:0]  sel_addr;
    logic [31:0] sel_data;

    // Round-robin search: first valid requester starting at rr_ptr, wrapping
    // modulo N_REQ. Inner loop keeps every vector index a loop constant.
    always_comb begin
        int idx;
        gnt_found = 1'b0;
        gnt_idx   = 3'd0;
        idx       = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= N_REQ) idx = idx - N_REQ;
            for (int k = 0; k < N_REQ; k++) begin
                if (!gnt_found && idx == k && i_req_valid[k]) begin
                    gnt_found = 1'b1;
                    gnt_idx   = 3'(k);
                end
            end
        end
    end

    // Ready only in ARB without a pending scrub; since ready implies valid,
    // gnt_ok is the handshake itself.
    assign gnt_ok = (state_q == ST_ARB) && !i_scrub && gnt_found;

    always_comb begin
        o_req_ready = '0;
        sel_addr    = 5'd0;
        sel_data    = 32'd0;
        for (int k = 0; k < N_REQ; k++) begin
            if (gnt_idx == 3'(k)) begin
                o_req_ready[k] = gnt_ok;
                sel_addr       = i_req_addr[5*k +: 5];
                sel_data       = i_req_data[32*k +: 32];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rr_ptr_d    = rr_ptr_q;
        wren_d      = 1'b0;
        addr_d      = addr_q;
        data_d      = data_q;
        gid_d       = gid_q;
        init_done_d = init_done_q;
        case (state_q)
            ST_INIT: begin
                wren_d = 1'b1;
                addr_d = cnt_q;
                data_d = 32'd0;
                if (cnt_q == 5'd31) begin
                    state_d     = ST_ARB;
                    init_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            default: begin
                if (i_scrub) begin
                    state_d     = ST_INIT;
                    cnt_d       = 5'd1;
                    init_done_d = 1'b0;
                end else if (gnt_ok) begin
                    rr_ptr_d = (gnt_idx == 3'(N_REQ - 1)) ? 3'd0 : gnt_idx + 3'd1;
`ifdef RFARB_X0_DROP_EN
                    // x0 writes are swallowed here; output fields hold.
                    if (sel_addr != 5'd0) begin
                        wren_d = 1'b1;
                        addr_d = sel_addr;
                        data_d = sel_data;
                        gid_d  = gnt_idx;
                    end
`else
                    wren_d = 1'b1;
                    addr_d = sel_addr;
                    data_d = sel_data;
                    gid_d  = gnt_idx;
`endif
                end
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q     <= SCRUB_EN ? ST_INIT : ST_ARB;
            cnt_q       <= 5'd1;
            rr_ptr_q    <= 3'd0;
            wren_q      <= 1'b0;
            addr_q      <= 5'd0;
            data_q      <= 32'd0;
            gid_q       <= 3'd0;
            init_done_q <= !SCRUB_EN;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rr_ptr_q    <= rr_ptr_d;
            wren_q      <= wren_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            gid_q       <= gid_d;
            init_done_q <= init_done_d;
        end
    end

    assign o_rd_wren   = wren_q;
    assign o_rd_addr   = addr_q;
    assign o_rd_data   = data_q;
    assign o_grant_id  = gid_q;
    assign o_init_done = init_done_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_wr_arbiter
//
// Scoreboard bench for regfile_wr_arbiter (N_REQ=3, SCRUB_EN=1). A behavioural
// model (scrub counter, round-robin pointer, pending-request arrays) runs in
// the stimulus process, checks o_req_ready / o_init_done each cycle and pushes
// every write it expects onto a queue; a monitor pops and compares whenever
// the DUT drives o_rd_wren.
// -----------------------------------------------------------------------------
module tb_regfile_wr_arbiter;
    localparam int N = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            scrub;
    logic [N-1:0]    req_valid;
    logic [5*N-1:0]  req_addr;
    logic [32*N-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            rd_wren;
    logic [4:0]      rd_addr;
    logic [31:0]     rd_data;
    logic [2:0]      grant_id;
    logic            init_done;

    always #5 clk = ~clk;

    regfile_wr_arbiter #(.N_REQ(N), .SCRUB_EN(1'b1)) dut (
        .i_clk       (clk),
        .i_rstn      (rst_n),
        .i_scrub     (scrub),
        .i_req_valid (req_valid),
        .i_req_addr  (req_addr),
        .i_req_data  (req_data),
        .o_req_ready (req_ready),
        .o_rd_wren   (rd_wren),
        .o_rd_addr   (rd_addr),
        .o_rd_data   (rd_data),
        .o_grant_id  (grant_id),
        .o_init_done (init_done)
    );

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
        int          gid;
        bit          is_scrub;
    } wr_t;

    wr_t expq[$];
    int  checks   = 0;
    int  failures = 0;

    // Reference model state
    bit          m_init;
    int          m_cnt;
    int          m_rr;
    bit          pend  [N];
    logic [4:0]  paddr [N];
    logic [31:0] pdata [N];
    bit          scrub_next;
    int          phase;   // 0: no new requests, 1: all valid, 2: random

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: every DUT write must match the oldest expected write.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && rd_wren === 1'b1) begin
            if (expq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write actual=addr %0d data %0h required=no write",
                         rd_addr, rd_data);
            end else begin
                wr_t e;
                e = expq.pop_front();
                chk("wr_addr", 64'(rd_addr), 64'(e.a));
                chk("wr_data", 64'(rd_data), 64'(e.d));
                if (!e.is_scrub) chk("wr_grant_id", 64'(grant_id), 64'(e.gid));
            end
        end
    end

    task automatic gen();
        for (int k = 0; k < N; k++) begin
            if (!pend[k]) begin
                if (phase == 1) begin
                    pend[k]  = 1'b1;
                    paddr[k] = 5'(5 + k);
                    pdata[k] = $urandom;
                end else if (phase == 2 && $urandom_range(1, 0) == 1) begin
                    pend[k]  = 1'b1;
                    paddr[k] = 5'($urandom_range(31, 0));
                    pdata[k] = $urandom;
                end
            end
        end
        if (phase == 2 && $urandom_range(63, 0) == 0) scrub_next = 1'b1;
    endtask

    task automatic drive();
        scrub = scrub_next;
        for (int k = 0; k < N; k++) begin
            req_valid[k]          = pend[k];
            req_addr[5*k +: 5]    = paddr[k];
            req_data[32*k +: 32]  = pdata[k];
        end
    endtask

    // Model step for the current cycle, evaluated just before the next edge.
    task automatic eval();
        logic [N-1:0] exp_rdy;
        int g;
        exp_rdy = '0;
        g = -1;
        chk("init_done", 64'(init_done), 64'(!m_init));
        if (m_init) begin
            expq.push_back('{a: 5'(m_cnt), d: 32'h0, gid: 0, is_scrub: 1'b1});
            m_cnt++;
            if (m_cnt > 31) m_init = 1'b0;
        end else if (scrub) begin
            m_init = 1'b1;
            m_cnt  = 1;
        end else begin
            for (int i = 0; i < N; i++) begin
                int k;
                k = (m_rr + i) % N;
                if (pend[k] && g < 0) g = k;
            end
            if (g >= 0) begin
                exp_rdy[g] = 1'b1;
`ifdef RFARB_X0_DROP_EN
                if (paddr[g] != 5'd0)
                    expq.push_back('{a: paddr[g], d: pdata[g], gid: g, is_scrub: 1'b0});
`else
                expq.push_back('{a: paddr[g], d: pdata[g], gid: g, is_scrub: 1'b0});
`endif
                pend[g] = 1'b0;
                m_rr    = (g + 1) % N;
            end
        end
        chk("ready", 64'(req_ready), 64'(exp_rdy));
        scrub_next = 1'b0;
    endtask

    task automatic step_rest();
        gen();
        drive();
        #3;
        eval();
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        step_rest();
    endtask

    task automatic drain(input int bound);
        int n;
        n = 0;
        phase = 0;
        while ((pend[0] || pend[1] || pend[2] || m_init) && n < bound) begin
            cycle();
            n++;
        end
        if (pend[0] || pend[1] || pend[2] || m_init) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout actual=pending required=idle");
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_wren", 64'(rd_wren), 64'd0);
        chk("rst_addr", 64'(rd_addr), 64'd0);
        chk("rst_data", 64'(rd_data), 64'd0);
        chk("rst_gid", 64'(grant_id), 64'd0);
        chk("rst_init_done", 64'(init_done), 64'd0);
        chk("rst_ready", 64'(req_ready), 64'd0);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        m_init = 1'b1;
        m_cnt  = 1;
        m_rr   = 0;
        step_rest();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        scrub_next = 1'b0;
        phase      = 0;
        m_init     = 1'b1;
        m_cnt      = 1;
        m_rr       = 0;
        for (int k = 0; k < N; k++) begin
            pend[k]  = 1'b1;               // valid during reset and INIT
            paddr[k] = 5'(20 + k);
            pdata[k] = 32'hA000_0000 + k;
        end
        drive();
        repeat (3) @(posedge clk);
        #2;
        chk_reset_outputs();

        // Power-up scrub with all requesters valid: ready must stay 0.
        release_reset();
        phase = 0;
        while (m_init) cycle();
        drain(10);

        // All three valid continuously: grants rotate, one write per cycle.
        phase = 1;
        repeat (12) cycle();
        drain(10);

        // Only requester 1.
        pend[1] = 1'b1; paddr[1] = 5'd9; pdata[1] = 32'hDEADBEEF;
        drain(10);

        // Bring rr_ptr to 0, then two requesters racing for x4.
        if (m_rr != 0) begin
            pend[N-1] = 1'b1; paddr[N-1] = 5'd3; pdata[N-1] = 32'h33;
            drain(10);
        end
        pend[0] = 1'b1; paddr[0] = 5'd4; pdata[0] = 32'h11;
        pend[2] = 1'b1; paddr[2] = 5'd4; pdata[2] = 32'h22;
        drain(10);

        // Re-scrub with requester 0 waiting.
        pend[0] = 1'b1; paddr[0] = 5'd12; pdata[0] = 32'h1234_5678;
        scrub_next = 1'b1;
        cycle();
        drain(40);

        // Write to x0.
        pend[0] = 1'b1; paddr[0] = 5'd0; pdata[0] = 32'h0000_ABCD;
        drain(10);

        // Random traffic with occasional re-scrubs.
        phase = 2;
        repeat (400) cycle();
        drain(40);

        // Reset in the middle of a scrub, at cnt=17.
        scrub_next = 1'b1;
        cycle();
        while (!(m_init && m_cnt == 17)) cycle();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs();
        expq.delete();
        @(posedge clk);
        release_reset();
        chk("restart_init_done", 64'(init_done), 64'd0);
        phase = 0;
        drain(40);
        repeat (3) cycle();

        chk("queue_empty", 64'(expq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
